prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream boot loader sitting directly upstream of the byte-write/word-read program RAM. It consumes bytes from the UART receiver and parses a framed image: sync, 16-bit length, payload, checksum. It writes the payload bytes sequentially into program RAM from address 0. It holds the CPU in reset until a frame loads with a good checksum, then returns a one-byte ACK/NAK to the UART transmitter.

## Interface
- `MEM_SIZE`, 1024: program RAM size in bytes; `ADDRW = $clog2(MEM_SIZE)`.
- `TIMEOUT_CYC`, 1_000_000: maximum idle cycles between bytes inside a frame.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts byte; handshake = `rx_valid & rx_ready`.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  response pending.
- `tx_ready`  in  1  transmitter accepts `tx_data`.
- `ram_we`  out  1  program RAM byte write enable.
- `ram_addr`  out  ADDRW  program RAM byte address.
- `ram_din`  out  8  program RAM write byte.
- `cpu_rst`  out  1  CPU reset request, active-high.
- `load_busy`  out  1  frame in progress (any state except IDLE).
- `load_err`  out  1  sticky error from the last frame.

## Operation
- Frame format: `SYNC` (0xA5), `LEN_LO`, `LEN_HI`, then L payload bytes, then `CSUM`. L is a little-endian byte count. `CSUM` = sum of the payload bytes mod 256.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, RESP.
- IDLE: bytes other than 0xA5 are accepted and discarded. 0xA5 moves to LEN_LO, clears `load_err`, sets `cpu_rst`, and clears the byte counter and checksum accumulator.
- LEN_LO -> LEN_HI: latch the length low byte.
- LEN_HI: latch the high byte. If L == 0 or L > MEM_SIZE, go to RESP with NAK and consume no payload. Otherwise go to DATA.
- DATA: each accepted byte produces one RAM write at address `cnt`. The byte is added to the 8-bit accumulator and `cnt` increments. When byte L-1 is accepted, go to CSUM.
- CSUM: the accepted byte is compared with the accumulator. On match, queue ACK (0x06). On mismatch, queue NAK (0x15) and set `load_err`. Then go to RESP.
- RESP: `tx_valid`=1 with the queued byte. On `tx_valid & tx_ready`, return to IDLE. Completing an ACK handshake also clears `cpu_rst`. After a NAK, `cpu_rst` stays 1.
- `rx_ready` = 1 in every state except RESP, where it is 0.
- Timeout: in LEN_LO, LEN_HI, DATA and CSUM, a counter increments every cycle without an rx handshake and clears on each handshake. When it reaches TIMEOUT_CYC: go to IDLE, set `load_err`, send no response, keep `cpu_rst` at 1. RAM contents written so far are left as they are.
- Width rules:
  - `cnt` is 16 bits.
  - `ram_addr` = `cnt[ADDRW-1:0]`. This never wraps, because L ≤ MEM_SIZE is enforced.
  - The accumulator is 8 bits with natural wrap.
- Reset values:
  - `cpu_rst`=1: CPU is held until the first good load.
  - `rx_ready`=1, state IDLE.
  - `tx_valid`=0, `tx_data`=0.
  - `ram_we`=0, `ram_addr`=0, `ram_din`=0.
  - `load_busy`=0, `load_err`=0.
  - All counters are 0.
- Reset mid-frame: immediate return to IDLE with all outputs at their reset values. A partial image remains in RAM.

## Timing
- `ram_we`, `ram_addr` and `ram_din` are registered. They assert exactly one cycle after the DATA handshake, for one cycle per byte.
- Back-to-back bytes, one per cycle, are sustained in every state except RESP.
- `tx_valid` rises the cycle after the CSUM handshake (or after the bad-length LEN_HI handshake). It holds, with `tx_data` stable, until `tx_ready`.
- `cpu_rst` rises the cycle after the sync handshake. It falls the cycle after the ACK tx handshake.
- The last RAM write completes at least one cycle before `cpu_rst` deasserts.
- The RAM reads its input in the same `clk` domain. No CDC inside this block.

## Structure
- Package `prog_pkg`:
  - state enum `loader_state_t`;
  - localparams `PROG_SYNC`=8'hA5, `PROG_ACK`=8'h06, `PROG_NAK`=8'h15.
- Single module with no sub-modules. The timeout counter is inline, with width `$clog2(TIMEOUT_CYC+1)`.
- Top-level pairing: `prog_loader` RAM outputs connect straight to the program RAM write port. `cpu_rst` is ORed into the core reset.

## Test plan
- Good frame: A5 04 00 11 22 33 44 AA -> writes (0,11),(1,22),(2,33),(3,44) one cycle after each byte. Then tx 0x06 and `cpu_rst` falls. The word at RAM address 0 reads 0x44332211.
- Bad checksum: same frame with CSUM 0xAB -> four writes, tx 0x15, `load_err`=1, `cpu_rst` stays 1.
- Bad length: A5 01 04 (L=1025 with MEM_SIZE=1024) -> no writes, tx 0x15 immediately. Bytes are refused (`rx_ready`=0) until the tx handshake.
- Noise plus backpressure: 00 FF A5 01 00 7E 7E with `tx_ready` held low 5 cycles -> the first two bytes are discarded. `tx_valid` holds 0x06 stable for 5 cycles, then IDLE.
- Timeout: A5 02 00 10, then silence for TIMEOUT_CYC cycles (set to 16) -> IDLE, `load_err`=1, no tx, `cpu_rst`=1. One write at addr 0.
- Reset mid-DATA: assert `rst` after the second payload byte -> all outputs at reset values the same cycle. A fresh good frame then loads normally.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared definitions for the program boot loader: FSM states and frame byte codes.
package prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_RESP
    } loader_state_t;

    localparam logic [7:0] PROG_SYNC = 8'hA5;
    localparam logic [7:0] PROG_ACK  = 8'h06;
    localparam logic [7:0] PROG_NAK  = 8'h15;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream boot loader: parses SYNC/LEN/payload/CSUM frames from the UART,
// writes the payload into program RAM from address 0, holds the CPU in reset
// until a frame with a good checksum lands, then answers with ACK or NAK.
module prog_loader
    import prog_pkg::*;
#(
    parameter int MEM_SIZE    = 1024,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int ADDRW       = $clog2(MEM_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             ram_we,
    output logic [ADDRW-1:0] ram_addr,
    output logic [7:0]       ram_din,
    output logic             cpu_rst,
    output logic             load_busy,
    output logic             load_err
);

    localparam int               TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [16:0]      MEM_LIMIT = 17'(MEM_SIZE);

    loader_state_t  state_q;
    logic [7:0]     len_lo_q;
    logic [15:0]    len_q;
    logic [15:0]    cnt_q;
    logic [7:0]     acc_q;
    logic [TW-1:0]  tmo_q;

    logic           rx_fire;
    logic           tx_fire;
    logic [15:0]    len_full;
    logic           in_frame;
    logic           timeout_hit;
    logic           len_bad;

    // Handshakes, the full length as it arrives, and the timeout condition.
    assign rx_ready    = (state_q != ST_RESP);
    assign load_busy   = (state_q != ST_IDLE);
    assign rx_fire     = rx_valid & rx_ready;
    assign tx_fire     = tx_valid & tx_ready;
    assign len_full    = {rx_data, len_lo_q};
    assign len_bad     = (len_full == 16'd0) || ({1'b0, len_full} > MEM_LIMIT);
    assign in_frame    = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                         (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign timeout_hit = in_frame && !rx_fire && (tmo_q == TMO_LAST);

    // Frame parser FSM with registered RAM, response and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            tmo_q    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            cpu_rst  <= 1'b1;
            load_err <= 1'b0;
        end else begin
            // NOTE: every assignment here is non-blocking so all registers update from the
            // same pre-edge values; a later assignment in this block simply overrides an earlier one.
            ram_we <= 1'b0;

            if (in_frame && !rx_fire) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_fire && rx_data == PROG_SYNC) begin
                        state_q  <= ST_LEN_LO;
                        load_err <= 1'b0;
                        cpu_rst  <= 1'b1;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_fire) begin
                        len_lo_q <= rx_data;
                        state_q  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_fire) begin
                        len_q <= len_full;
                        if (len_bad) begin
                            tx_data  <= PROG_NAK;
                            tx_valid <= 1'b1;
                            state_q  <= ST_RESP;
                        end else begin
                            state_q  <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        ram_we   <= 1'b1;
                        ram_addr <= cnt_q[ADDRW-1:0];
                        ram_din  <= rx_data;
                        acc_q    <= acc_q + rx_data;
                        cnt_q    <= cnt_q + 16'd1;
                        if (cnt_q == len_q - 16'd1) begin
                            state_q <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_fire) begin
                        tx_valid <= 1'b1;
                        state_q  <= ST_RESP;
                        if (rx_data == acc_q) begin
                            tx_data <= PROG_ACK;
                        end else begin
                            tx_data  <= PROG_NAK;
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (tx_data == PROG_ACK) begin
                            cpu_rst <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A silent sender abandons the frame: no response, CPU stays held.
            if (timeout_hit) begin
                state_q  <= ST_IDLE;
                load_err <= 1'b1;
                tmo_q    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_prog_loader;

    localparam int MEM_SIZE = 1024;
    localparam int ADDRW    = $clog2(MEM_SIZE);
    localparam int TMO      = 16;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             ram_we;
    logic [ADDRW-1:0] ram_addr;
    logic [7:0]       ram_din;
    logic             cpu_rst;
    logic             load_busy;
    logic             load_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_model [MEM_SIZE];
    int         wr_count = 0;

    prog_loader #(.MEM_SIZE(MEM_SIZE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .cpu_rst(cpu_rst), .load_busy(load_busy), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Program RAM stand-in: records every write the loader issues.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            mem_model[ram_addr] = ram_din;
            wr_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // Offer one byte from a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        rx_data  = b;
        rx_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rx_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for a response, hold tx_ready low for 'hold' cycles checking stability, then accept.
    task automatic get_resp(input int hold, output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'hxx;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            b = tx_data;
            repeat (hold) begin
                @(negedge clk);
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== b || rx_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_hold: tx_valid=%b tx_data=%h rx_ready=%b, required 1/%h/0",
                             tx_valid, tx_data, rx_ready, b);
                end
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
    endtask

    // Send a complete frame and check it against the frame-level model.
    task automatic run_frame(input logic [7:0] pl[$], input int len, input logic [7:0] csum,
                             input int hold, input int gap, input string tag);
        logic [7:0] sum;
        logic [7:0] exp_rsp;
        logic [7:0] rsp;
        bit         len_ok;
        bit         ok;
        int         wr0;
        sum = 8'h00;
        foreach (pl[i]) sum = sum + pl[i];
        len_ok  = (len >= 1) && (len <= MEM_SIZE);
        exp_rsp = !len_ok ? NAK : ((sum == csum) ? ACK : NAK);
        wr0     = wr_count;

        send_byte(8'hA5, ok);
        checks++;
        if (!ok || cpu_rst !== 1'b1 || load_busy !== 1'b1 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_sync: ok=%0d cpu_rst=%b busy=%b err=%b, required 1/1/1/0",
                     tag, ok, cpu_rst, load_busy, load_err);
        end
        idle($urandom_range(0, gap));
        send_byte(len[7:0], ok);
        idle($urandom_range(0, gap));
        send_byte(len[15:8], ok);
        if (len_ok) begin
            for (int k = 0; k < len; k++) begin
                idle($urandom_range(0, gap));
                send_byte(pl[k], ok);
                checks++;
                if (!ok || ram_we !== 1'b1 || ram_addr !== k[ADDRW-1:0] || ram_din !== pl[k]) begin
                    failures++;
                    $display("FAIL %s_write[%0d]: ok=%0d we=%b addr=%0d din=%h, required 1/1/%0d/%h",
                             tag, k, ok, ram_we, ram_addr, ram_din, k, pl[k]);
                end
            end
            idle($urandom_range(0, gap));
            send_byte(csum, ok);
        end
        checks++;
        if (tx_valid !== 1'b1 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_resp_rise: tx_valid=%b rx_ready=%b, required 1/0",
                     tag, tx_valid, rx_ready);
        end
        get_resp(hold, rsp, ok);
        checks++;
        if (!ok || rsp !== exp_rsp) begin
            failures++;
            $display("FAIL %s_resp: ok=%0d byte=%h, required %h", tag, ok, rsp, exp_rsp);
        end
        checks++;
        if (cpu_rst !== (exp_rsp == ACK ? 1'b0 : 1'b1) || load_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: cpu_rst=%b busy=%b, required %b/0",
                     tag, cpu_rst, load_busy, (exp_rsp == ACK ? 1'b0 : 1'b1));
        end
        checks++;
        if (wr_count - wr0 != (len_ok ? len : 0)) begin
            failures++;
            $display("FAIL %s_wr_count: got=%0d, required %0d", tag, wr_count - wr0, len_ok ? len : 0);
        end
        if (len_ok) begin
            checks++;
            if (load_err !== (exp_rsp == NAK)) begin
                failures++;
                $display("FAIL %s_load_err: got=%b, required %b", tag, load_err, exp_rsp == NAK);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        idle(3);
        checks++;
        if (cpu_rst !== 1'b1 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
            ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== 8'h00 ||
            load_busy !== 1'b0 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: cpu_rst=%b rx_ready=%b tx_valid=%b tx_data=%h we=%b addr=%0d din=%h busy=%b err=%b",
                     cpu_rst, rx_ready, tx_valid, tx_data, ram_we, ram_addr, ram_din, load_busy, load_err);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        logic [7:0] pl[$];
        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(pl, 4, 8'hAA, 0, 0, "good");
        checks++;
        if ({mem_model[3], mem_model[2], mem_model[1], mem_model[0]} !== 32'h44332211) begin
            failures++;
            $display("FAIL good_word0: got=%h, required 44332211",
                     {mem_model[3], mem_model[2], mem_model[1], mem_model[0]});
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] pl[$];
        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(pl, 4, 8'hAB, 0, 0, "badcsum");
    endtask

    task automatic test_bad_len();
        bit ok;
        int wr0;
        wr0 = wr_count;
        send_byte(8'hA5, ok);
        send_byte(8'h01, ok);
        send_byte(8'h04, ok);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== NAK || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL badlen_nak: tx_valid=%b tx_data=%h rx_ready=%b, required 1/%h/0",
                     tx_valid, tx_data, rx_ready, NAK);
        end
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rx_ready !== 1'b0 || tx_valid !== 1'b1) begin
                failures++;
                $display("FAIL badlen_refuse[%0d]: rx_ready=%b tx_valid=%b, required 0/1",
                         i, rx_ready, tx_valid);
            end
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        checks++;
        if (load_busy !== 1'b0 || tx_valid !== 1'b0 || cpu_rst !== 1'b1 || wr_count != wr0) begin
            failures++;
            $display("FAIL badlen_after: busy=%b tx_valid=%b cpu_rst=%b writes=%0d, required 0/0/1/0",
                     load_busy, tx_valid, cpu_rst, wr_count - wr0);
        end
    endtask

    task automatic test_noise_backpressure();
        logic [7:0] pl[$];
        bit ok;
        int wr0;
        wr0 = wr_count;
        send_byte(8'h00, ok);
        send_byte(8'hFF, ok);
        checks++;
        if (!ok || load_busy !== 1'b0 || wr_count != wr0) begin
            failures++;
            $display("FAIL noise_discard: ok=%0d busy=%b writes=%0d, required 1/0/0",
                     ok, load_busy, wr_count - wr0);
        end
        pl = {8'h7E};
        run_frame(pl, 1, 8'h7E, 5, 0, "noise");
    endtask

    task automatic test_timeout();
        bit ok;
        bit saw_tx;
        int wr0;
        wr0    = wr_count;
        saw_tx = 1'b0;
        send_byte(8'hA5, ok);
        send_byte(8'h02, ok);
        send_byte(8'h00, ok);
        send_byte(8'h10, ok);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== '0 || ram_din !== 8'h10) begin
            failures++;
            $display("FAIL tmo_write: we=%b addr=%0d din=%h, required 1/0/10", ram_we, ram_addr, ram_din);
        end
        for (int i = 1; i <= TMO + 4; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) saw_tx = 1'b1;
            if (i == TMO - 3) begin
                checks++;
                if (load_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL tmo_early: busy=%b after %0d idle cycles, required 1", load_busy, i);
                end
            end
        end
        checks++;
        if (load_busy !== 1'b0 || load_err !== 1'b1 || cpu_rst !== 1'b1 || saw_tx || wr_count - wr0 != 1) begin
            failures++;
            $display("FAIL tmo_after: busy=%b err=%b cpu_rst=%b saw_tx=%0d writes=%0d, required 0/1/1/0/1",
                     load_busy, load_err, cpu_rst, saw_tx, wr_count - wr0);
        end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] pl[$];
        logic [7:0] sum;
        bit ok;
        send_byte(8'hA5, ok);
        send_byte(8'h04, ok);
        send_byte(8'h00, ok);
        send_byte(8'h11, ok);
        send_byte(8'h22, ok);
        rst = 1'b1;
        #1;
        checks++;
        if (cpu_rst !== 1'b1 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
            ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== 8'h00 ||
            load_busy !== 1'b0 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_values: cpu_rst=%b rx_ready=%b tx_valid=%b tx_data=%h we=%b addr=%0d din=%h busy=%b err=%b",
                     cpu_rst, rx_ready, tx_valid, tx_data, ram_we, ram_addr, ram_din, load_busy, load_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pl  = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sum = 8'hDE + 8'hAD + 8'hBE + 8'hEF;
        run_frame(pl, 4, sum, 1, 0, "midrst");
    endtask

    task automatic test_random_frames();
        logic [7:0] pl[$];
        logic [7:0] sum;
        int         len;
        for (int f = 0; f < 8; f++) begin
            pl.delete();
            len = $urandom_range(1, 24);
            sum = 8'h00;
            for (int k = 0; k < len; k++) begin
                pl.push_back(8'($urandom));
                sum = sum + pl[k];
            end
            if ($urandom_range(0, 1) == 1) sum = sum ^ 8'($urandom_range(1, 255));
            run_frame(pl, len, sum, $urandom_range(0, 4), 3, "rand");
            idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_noise_backpressure();
        test_timeout();
        test_reset_mid_data();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
